// File: rtl/poly_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : poly_mul_pkg
//  Description : Shared ternary code points, FSM state encoding and the
//                ternary-code decoder for the streaming polynomial multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package poly_mul_pkg;

    // Two-bit ternary coefficient encoding
    localparam logic [1:0] TERN_ZERO = 2'b00;
    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;
    localparam logic [1:0] TERN_RSVD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic add;
        logic sub;
        logic err;
    } tern_dec_t;

    // Reserved code contributes nothing but is flagged so the caller can latch it
    function automatic tern_dec_t tern_decode(input logic [1:0] code);
        tern_dec_t d;
        d = '0;
        case (code)
            TERN_POS:  d.add = 1'b1;
            TERN_NEG:  d.sub = 1'b1;
            TERN_RSVD: d.err = 1'b1;
            default:   d = '0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/poly_mac_cell.sv
`default_nettype none
// ============================================================================
//  Module      : poly_mac_cell
//  Description : One coefficient lane: acc +/- h or pass-through, mod 2^LOG_Q.
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_mac_cell #(
    parameter int LOG_Q = 13
) (
    input  logic [LOG_Q-1:0] acc_in,
    input  logic [LOG_Q-1:0] h_in,
    input  logic             add,
    input  logic             sub,
    output logic [LOG_Q-1:0] acc_out
);

    // Wrap-around add/subtract; truncation to LOG_Q bits is the modular reduction
    always_comb begin
        acc_out = acc_in;
        if (add) begin
            acc_out = acc_in + h_in;
        end else if (sub) begin
            acc_out = acc_in - h_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/poly_ternary_mul_stream.sv
`default_nettype none
// ============================================================================
//  Module      : poly_ternary_mul_stream
//  Description : e = r*h mod (x^N -/+ 1), coefficients mod 2^LOG_Q. h loaded
//                in parallel on start, ternary r streamed one coefficient per
//                valid/ready beat. h rotates one lane per beat so every lane
//                performs a single ternary MAC against its local accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_ternary_mul_stream
    import poly_mul_pkg::*;
#(
    parameter int N     = 701,
    parameter int LOG_Q = 13,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 neg_mode,
    input  logic [N*LOG_Q-1:0]   h,
    input  logic                 r_valid,
    input  logic [1:0]           r_coef,
    output logic                 r_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 e_valid,
    output logic [N*LOG_Q-1:0]   e,
    output logic                 err_code
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_mode;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic               r_e_valid;
    logic [LOG_Q-1:0]   r_h   [N];
    logic [LOG_Q-1:0]   r_acc [N];
    logic [LOG_Q-1:0]   w_acc_next [N];
    logic [LOG_Q-1:0]   w_wrap;
    logic               w_load;
    logic               w_beat;
    logic               w_last;
    tern_dec_t          w_dec;

    assign w_dec  = tern_decode(r_coef);
    assign w_load = (r_state == IDLE) && start;
    assign w_beat = (r_state == RUN) && r_valid;
    assign w_last = w_beat && (r_cnt == CNT_W'(N - 1));
    // Coefficient leaving the top lane re-enters lane 0, negated for x^N = -1
    assign w_wrap = r_mode ? (LOG_Q'(0) - r_h[N-1]) : r_h[N-1];

    // One MAC lane per coefficient; accumulator lanes pack straight onto e
    generate
        for (genvar j = 0; j < N; j++) begin : g_lane
            poly_mac_cell #(
                .LOG_Q   (LOG_Q)
            ) u_cell (
                .acc_in  (r_acc[j]),
                .h_in    (r_h[j]),
                .add     (w_dec.add),
                .sub     (w_dec.sub),
                .acc_out (w_acc_next[j])
            );
            assign e[j*LOG_Q +: LOG_Q] = r_acc[j];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE on last beat, DONE lasts one cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: load h and clear on start, MAC + rotate on each accepted beat, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= 1'b0;
            r_cnt  <= '0;
            for (int j = 0; j < N; j++) begin
                r_h[j]   <= '0;
                r_acc[j] <= '0;
            end
        end else if (w_load) begin
            r_mode <= neg_mode;
            r_cnt  <= '0;
            for (int j = 0; j < N; j++) begin
                r_h[j]   <= h[j*LOG_Q +: LOG_Q];
                r_acc[j] <= '0;
            end
        end else if (w_beat) begin
            r_cnt  <= r_cnt + 1'b1;
            r_h[0] <= w_wrap;
            for (int j = 1; j < N; j++) begin
                r_h[j] <= r_h[j-1];
            end
            for (int j = 0; j < N; j++) begin
                r_acc[j] <= w_acc_next[j];
            end
        end
    end

    // Status flags: e_valid set by the final beat, err sticky until the next start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_valid <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_load) begin
            r_e_valid <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_last) begin
                r_e_valid <= 1'b1;
            end
            if (w_beat && w_dec.err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign r_ready  = (r_state == RUN);
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign e_valid  = r_e_valid;
    // Reserved code is visible in the same cycle it is accepted
    assign err_code = r_err | (w_beat & w_dec.err);

endmodule
`default_nettype wire

// File: tb/tb_poly_ternary_mul_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_poly_ternary_mul_stream
//  Description : Self-checking bench: directed N=4/LOG_Q=4 instance plus a
//                randomized default-size instance against a convolution model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_ternary_mul_stream;

    localparam int NS = 4;
    localparam int LS = 4;
    localparam int NB = 701;
    localparam int LB = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Small instance
    logic              s_start = 0, s_neg = 0, s_r_valid = 0;
    logic [1:0]        s_r_coef = 0;
    logic [NS*LS-1:0]  s_h = '0;
    logic              s_r_ready, s_busy, s_done, s_e_valid, s_err;
    logic [NS*LS-1:0]  s_e;

    // Default-size instance
    logic              b_start = 0, b_neg = 0, b_r_valid = 0;
    logic [1:0]        b_r_coef = 0;
    logic [NB*LB-1:0]  b_h = '0;
    logic              b_r_ready, b_busy, b_done, b_e_valid, b_err;
    logic [NB*LB-1:0]  b_e;

    poly_ternary_mul_stream #(.N(NS), .LOG_Q(LS)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .neg_mode(s_neg), .h(s_h),
        .r_valid(s_r_valid), .r_coef(s_r_coef), .r_ready(s_r_ready),
        .busy(s_busy), .done(s_done), .e_valid(s_e_valid), .e(s_e),
        .err_code(s_err)
    );

    poly_ternary_mul_stream u_big (
        .clk(clk), .rst(rst), .start(b_start), .neg_mode(b_neg), .h(b_h),
        .r_valid(b_r_valid), .r_coef(b_r_coef), .r_ready(b_r_ready),
        .busy(b_busy), .done(b_done), .e_valid(b_e_valid), .e(b_e),
        .err_code(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: schoolbook ring product, x^N = +1 (cyclic) or -1 (negacyclic)
    function automatic void ref_conv(input int hq[NB], input int rv[NB], input bit neg,
                                     output int eq[NB]);
        for (int j = 0; j < NB; j++) eq[j] = 0;
        for (int k = 0; k < NB; k++) begin
            if (rv[k] != 0) begin
                for (int i = 0; i < NB; i++) begin
                    int idx, sgn;
                    idx = i + k;
                    sgn = rv[k];
                    if (idx >= NB) begin
                        idx = idx - NB;
                        if (neg) sgn = -sgn;
                    end
                    eq[idx] = eq[idx] + sgn * hq[i];
                end
            end
        end
        for (int j = 0; j < NB; j++) eq[j] = eq[j] & ((1 << LB) - 1);
    endfunction

    // One small-instance operation; returns edges from start edge to done visible
    task automatic small_run(input logic [15:0] hv, input bit neg,
                             input logic [1:0] r0, input logic [1:0] r1,
                             input logic [1:0] r2, input logic [1:0] r3,
                             input int gap, input bit poke, output int cyc);
        logic [1:0] rc [4];
        rc = '{r0, r1, r2, r3};
        s_h = hv; s_neg = neg; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("e_valid_cleared_on_start", s_e_valid, 1'b0);
        chk("err_cleared_on_start", s_err, 1'b0);
        chk("busy_in_run", {s_busy, s_r_ready}, 2'b11);
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    s_r_valid = 1'b0;
                    if (poke) begin
                        s_start = 1'b1; s_neg = ~neg; s_h = 16'hFFFF;
                    end
                    tick();
                    cyc++;
                    s_start = 1'b0;
                end
            end
            s_r_valid = 1'b1;
            s_r_coef  = rc[k];
            tick();
            cyc++;
        end
        s_r_valid = 1'b0;
        s_r_coef  = 2'b00;
    endtask

    task automatic big_run(input bit neg, input bit allow_rsvd);
        int hq [NB];
        int rv [NB];
        int eq [NB];
        logic [1:0] code [NB];
        logic [NB*LB-1:0] expv;
        bit exp_err;
        bit acc;
        int k, budget, bad;
        exp_err = 1'b0;
        for (int j = 0; j < NB; j++) begin
            hq[j] = int'($urandom_range(0, (1 << LB) - 1));
            if (allow_rsvd) code[j] = 2'($urandom_range(0, 3));
            else begin
                case ($urandom_range(0, 2))
                    0:       code[j] = 2'b00;
                    1:       code[j] = 2'b01;
                    default: code[j] = 2'b11;
                endcase
            end
            rv[j] = (code[j] == 2'b01) ? 1 : (code[j] == 2'b11) ? -1 : 0;
            if (code[j] == 2'b10) exp_err = 1'b1;
            b_h[j*LB +: LB] = LB'(hq[j]);
        end
        ref_conv(hq, rv, neg, eq);
        for (int j = 0; j < NB; j++) expv[j*LB +: LB] = LB'(eq[j]);

        b_neg = neg; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        k = 0; budget = 0;
        while (k < NB && budget < 6000) begin
            if ($urandom_range(0, 3) == 0) begin
                b_r_valid = 1'b0;
                b_r_coef  = 2'($urandom_range(0, 3));
            end else begin
                b_r_valid = 1'b1;
                b_r_coef  = code[k];
            end
            acc = b_r_valid && b_r_ready;
            tick();
            if (acc) k++;
            budget++;
        end
        b_r_valid = 1'b0;
        if (k < NB) begin
            checks++;
            errors++;
            $error("FAIL big_timeout: observed beats=%0d expected=%0d", k, NB);
        end
        chk("big_done", {b_done, b_e_valid, b_busy}, 3'b110);
        chk("big_err", b_err, exp_err);
        bad = 0;
        for (int j = NB - 1; j >= 0; j--) if (b_e[j*LB +: LB] !== expv[j*LB +: LB]) bad = j;
        checks++;
        assert (b_e === expv) else begin
            errors++;
            $error("FAIL big_e: coef %0d observed=%0h expected=%0h (neg=%0d)",
                   bad, b_e[bad*LB +: LB], expv[bad*LB +: LB], neg);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        // Reset state
        tick(); tick();
        chk("rst_e", s_e, 16'h0000);
        chk("rst_flags", {s_e_valid, s_done, s_busy, s_r_ready, s_err}, 5'b0);
        chk("rst_big_flags", {b_e_valid, b_done, b_busy, b_r_ready, b_err}, 5'b0);
        rst = 1'b0;
        tick();

        // r = 1 -> e = h; done exactly after the 4th beat edge
        small_run(16'h4321, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1'b0, cyc);
        chk("lat_nostall", cyc, 4);
        chk("done_flags", {s_done, s_e_valid, s_busy, s_r_ready}, 4'b1100);
        chk("e_identity", s_e, 16'h4321);
        tick();
        chk("after_done", {s_done, s_e_valid}, 2'b01);
        chk("e_held", s_e, 16'h4321);
        // r_valid in IDLE must be ignored
        s_r_valid = 1'b1; s_r_coef = 2'b01;
        tick(); tick();
        chk("idle_ready", s_r_ready, 1'b0);
        chk("idle_e_stable", s_e, 16'h4321);
        s_r_valid = 1'b0;

        // r = x: cyclic [4,1,2,3], negacyclic [12,1,2,3]
        small_run(16'h4321, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 0, 1'b0, cyc);
        chk("e_shift_cyc", s_e, 16'h3214);
        tick();
        small_run(16'h4321, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 0, 1'b0, cyc);
        chk("e_shift_neg", s_e, 16'h321C);
        tick();

        // r = all -1 -> each coefficient -10 mod 16 = 6
        small_run(16'h4321, 1'b0, 2'b11, 2'b11, 2'b11, 2'b11, 0, 1'b0, cyc);
        chk("e_all_neg", s_e, 16'h6666);
        tick();

        // Stalls of 3 between beats with start pokes during RUN
        small_run(16'h4321, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 3, 1'b1, cyc);
        chk("lat_stall", cyc, 13);
        chk("stall_done", s_done, 1'b1);
        chk("e_stall_neg", s_e, 16'h321C);
        tick();

        // Reserved code acts as 0 and raises sticky err: r = [rsvd, +1, 0, 0] -> x*h
        small_run(16'h4321, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 1'b0, cyc);
        chk("e_rsvd", s_e, 16'h3214);
        chk("err_set", s_err, 1'b1);
        tick(); tick();
        chk("err_sticky", s_err, 1'b1);

        // Abort mid-operation with asynchronous reset
        s_h = 16'h4321; s_neg = 1'b0; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("err_cleared_start2", s_err, 1'b0);
        s_r_valid = 1'b1; s_r_coef = 2'b01;
        tick(); tick();
        s_r_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_e", s_e, 16'h0000);
        chk("async_rst_flags", {s_e_valid, s_done, s_busy, s_r_ready, s_err}, 5'b0);
        tick();
        rst = 1'b0;
        tick();
        small_run(16'h4321, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1'b0, cyc);
        chk("post_rst_e", s_e, 16'h4321);
        chk("post_rst_done", s_done, 1'b1);
        tick();

        // Randomized default-size runs, both modes, random stalls
        for (int run = 0; run < 24; run++) begin
            big_run(run[0], (run % 4) == 3);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
